// File: rtl/lisnoc_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : lisnoc_packetizer
// Purpose  : Turns a command (dest, class, length) plus a raw data-word stream
//            into a LISNoC flit sequence: HEADER, PAYLOAD..., LAST, or a
//            single SINGLE flit for zero-length packets. One output register
//            stage with valid/ready back-pressure.
// Options  : LISNOC_PACKETIZER_CNT_EN adds a 16-bit completed-packet counter
//            output (pkt_count).
// Revision : 1.0  initial release
// ============================================================================
module lisnoc_packetizer #(
    parameter int data_width  = 32,
    parameter int dest_width  = 5,
    parameter int class_width = 3,
    parameter int max_payload = 8,
    localparam int size_width = $clog2(max_payload + 1),
    localparam int flit_width = data_width + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [dest_width-1:0]  cmd_dest,
    input  logic [class_width-1:0] cmd_class,
    input  logic [size_width-1:0]  cmd_len,
    output logic                   cmd_err,
`ifdef LISNOC_PACKETIZER_CNT_EN
    output logic [15:0]            pkt_count,
`endif
    input  logic [data_width-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [flit_width-1:0]  out_flit,
    output logic                   out_valid,
    input  logic                   out_ready
);

    // LISNoC flit type encoding (type lives in the two MSBs of the flit)
    localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
    localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

    localparam logic [size_width-1:0] MAX_LEN = size_width'(max_payload);
    localparam logic [size_width-1:0] ONE     = size_width'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [size_width-1:0]   remaining_q, remaining_d;
    logic [flit_width-1:0]   out_flit_q, out_flit_d;
    logic                    out_valid_q, out_valid_d;
    logic                    cmd_err_q, cmd_err_d;
    logic                    load_ok;
    logic [data_width-1:0]   hdr_data;

    // Output register can take a new flit when empty or being popped this cycle
    always_comb begin
        load_ok   = !out_valid_q || out_ready;
        cmd_ready = (state_q == ST_IDLE)    && load_ok;
        in_ready  = (state_q == ST_PAYLOAD) && load_ok;
    end

    // Header word: dest in the MSBs, class just below, length in the LSBs
    always_comb begin
        hdr_data = '0;
        hdr_data[data_width-1 -: dest_width]              = cmd_dest;
        hdr_data[data_width-dest_width-1 -: class_width]  = cmd_class;
        hdr_data[size_width-1:0]                          = cmd_len;
    end

    // Next-state, remaining-word counter and output-register load logic
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q && !out_ready;
        cmd_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_len > MAX_LEN) begin
                        cmd_err_d = 1'b1;
                    end else if (cmd_len == '0) begin
                        out_flit_d  = {FLIT_TYPE_SINGLE, hdr_data};
                        out_valid_d = 1'b1;
                    end else begin
                        out_flit_d  = {FLIT_TYPE_HEADER, hdr_data};
                        out_valid_d = 1'b1;
                        remaining_d = cmd_len;
                        state_d     = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (in_valid && in_ready) begin
                    out_valid_d = 1'b1;
                    if (remaining_q > ONE) begin
                        out_flit_d  = {FLIT_TYPE_PAYLOAD, in_data};
                        remaining_d = remaining_q - ONE;
                    end else begin
                        // Final word; counter saturates at zero
                        out_flit_d  = {FLIT_TYPE_LAST, in_data};
                        remaining_d = '0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output register, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign out_flit  = out_flit_q;
    assign out_valid = out_valid_q;
    assign cmd_err   = cmd_err_q;

`ifdef LISNOC_PACKETIZER_CNT_EN
    logic [15:0] pkt_count_q, pkt_count_d;

    // Count packets as their SINGLE or LAST flit leaves the output register
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (out_valid_q && out_ready &&
            ((out_flit_q[flit_width-1 -: 2] == FLIT_TYPE_SINGLE) ||
             (out_flit_q[flit_width-1 -: 2] == FLIT_TYPE_LAST))) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
    end

    // Packet counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count_q <= 16'd0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lisnoc_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lisnoc_packetizer
// Purpose  : Self-checking bench for lisnoc_packetizer. Expected flit stream
//            is a queue built from the packet list; a negedge monitor pops it
//            on every output handshake. Honours LISNOC_PACKETIZER_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_lisnoc_packetizer;

    localparam int DW    = 32;
    localparam int DESTW = 5;
    localparam int CLSW  = 3;
    localparam int MAXP  = 8;
    localparam int SW    = $clog2(MAXP + 1);
    localparam int FW    = DW + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [DESTW-1:0] cmd_dest = '0;
    logic [CLSW-1:0] cmd_class = '0;
    logic [SW-1:0]   cmd_len = '0;
    logic            cmd_err;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [FW-1:0]   out_flit;
    logic            out_valid;
    logic            out_ready = 1'b1;
`ifdef LISNOC_PACKETIZER_CNT_EN
    logic [15:0]     pkt_count;
`endif

    lisnoc_packetizer #(
        .data_width (DW),
        .dest_width (DESTW),
        .class_width(CLSW),
        .max_payload(MAXP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dest (cmd_dest),
        .cmd_class(cmd_class),
        .cmd_len  (cmd_len),
        .cmd_err  (cmd_err),
`ifdef LISNOC_PACKETIZER_CNT_EN
        .pkt_count(pkt_count),
`endif
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_flit (out_flit),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [FW-1:0] exp_q[$];
    logic [DW-1:0] data_q[$];
    int            pop_cyc[$];
    int            cyc = 0;
    int            or_mode = 0;
    int            data_pct = 100;
    bit            din_hs = 1'b0;
    bit            err_exp = 1'b0;
    bit            stall_prev = 1'b0;
    logic [FW-1:0] stall_flit = '0;
    logic [15:0]   cnt_model = 16'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Monitor: scoreboard pop on each output handshake plus per-cycle protocol rules
    always @(negedge clk) begin
        logic [FW-1:0] e;
        if (!rst) begin
            err_exp    = 1'b0;
            stall_prev = 1'b0;
            din_hs     = 1'b0;
        end else begin
            check("cmd_err", cmd_err, err_exp);
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_flit", out_flit, stall_flit);
            end
            if (out_valid && !out_ready) begin
                check("stall_cmd_ready", cmd_ready, 0);
                check("stall_in_ready", in_ready, 0);
            end
`ifdef LISNOC_PACKETIZER_CNT_EN
            check("pkt_count", pkt_count, cnt_model);
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_flit: got 0x%0h, expected no flit", out_flit);
                end else begin
                    e = exp_q.pop_front();
                    check("flit", out_flit, e);
                    pop_cyc.push_back(cyc);
                    if (e[FW-1]) cnt_model = cnt_model + 16'd1;
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_flit = out_flit;
            err_exp    = cmd_valid && cmd_ready && (int'(cmd_len) > MAXP);
            din_hs     = in_valid && in_ready;
        end
    end

    // Downstream ready pattern: steady, toggling or random
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Payload source: presents the head of data_q, retires it after a handshake
    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (din_hs && data_q.size() > 0) void'(data_q.pop_front());
            if (data_q.size() > 0 && $urandom_range(0, 99) < data_pct) begin
                in_valid = 1'b1;
                in_data  = data_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end
        end
    end

    // Hold a command until accepted (bounded)
    task automatic issue_cmd(input int d, input int c, input int l);
        bit ok;
        cmd_dest  = DESTW'(d);
        cmd_class = CLSW'(c);
        cmd_len   = SW'(l);
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_timeout: got no cmd_ready, expected accept within 200 cycles");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Reference model: expected flits derived from the packet description
    task automatic model_cmd(input int d, input int c, input int l);
        logic [63:0] h;
        logic [DW-1:0] w;
        if (l <= MAXP) begin
            h = (64'(d) << (DW - DESTW)) | (64'(c) << (DW - DESTW - CLSW)) | 64'(l);
            exp_q.push_back({(l == 0) ? 2'b11 : 2'b01, h[DW-1:0]});
            for (int i = 0; i < l; i++) begin
                w = $urandom;
                data_q.push_back(w);
                exp_q.push_back({(i == l - 1) ? 2'b10 : 2'b00, w});
            end
        end
        issue_cmd(d, c, l);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (exp_q.size() == 0 && data_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d flits pending, expected 0", exp_q.size());
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_flit", out_flit, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_cmd_err", cmd_err, 0);
`ifdef LISNOC_PACKETIZER_CNT_EN
        check("rst_pkt_count", pkt_count, 0);
`endif
        step();

        // Zero-length packet: one SINGLE flit, then idle output
        exp_q.push_back({2'b11, 32'h1800_0000});
        issue_cmd(3, 0, 0);
        @(negedge clk);
        check("single_valid", out_valid, 1);
        check("single_flit", out_flit, {2'b11, 32'h1800_0000});
        @(negedge clk);
        check("single_then_idle", out_valid, 0);
        step();
        exp_q.push_back({2'b11, 32'h1900_0000});
        issue_cmd(3, 1, 0);
        wait_drain();

        // len=3, data continuously valid: four flits on consecutive cycles
        data_q.push_back(32'hA);
        data_q.push_back(32'hB);
        data_q.push_back(32'hC);
        exp_q.push_back({2'b01, 32'h1000_0003});
        exp_q.push_back({2'b00, 32'h0000_000A});
        exp_q.push_back({2'b00, 32'h0000_000B});
        exp_q.push_back({2'b10, 32'h0000_000C});
        pop_cyc.delete();
        issue_cmd(2, 0, 3);
        wait_drain();
        check("len3_flit_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) check("len3_back_to_back", pop_cyc[3] - pop_cyc[0], 3);

        // Same packet with out_ready toggling
        or_mode = 1;
        data_q.push_back(32'hA);
        data_q.push_back(32'hB);
        data_q.push_back(32'hC);
        exp_q.push_back({2'b01, 32'h1000_0003});
        exp_q.push_back({2'b00, 32'h0000_000A});
        exp_q.push_back({2'b00, 32'h0000_000B});
        exp_q.push_back({2'b10, 32'h0000_000C});
        pop_cyc.delete();
        issue_cmd(2, 0, 3);
        wait_drain();
        check("toggle_flit_count", pop_cyc.size(), 4);
        or_mode = 0;
        step();

        // Two queued commands: HEADER, LAST, SINGLE with no gap
        data_q.push_back(32'h55);
        exp_q.push_back({2'b01, 32'h0800_0001});
        exp_q.push_back({2'b10, 32'h0000_0055});
        exp_q.push_back({2'b11, 32'h2200_0000});
        pop_cyc.delete();
        issue_cmd(1, 0, 1);
        issue_cmd(4, 2, 0);
        wait_drain();
        check("b2b_flit_count", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) check("b2b_no_gap", pop_cyc[2] - pop_cyc[0], 2);

        // Oversize command rejected, next legal command proceeds
        issue_cmd(0, 0, 9);
        @(negedge clk);
        check("err_pulse", cmd_err, 1);
        check("err_no_flit", out_valid, 0);
        @(negedge clk);
        check("err_one_cycle", cmd_err, 0);
        check("err_still_no_flit", out_valid, 0);
        step();
        data_q.push_back(32'h11);
        data_q.push_back(32'h22);
        exp_q.push_back({2'b01, 32'h2F00_0002});
        exp_q.push_back({2'b00, 32'h0000_0011});
        exp_q.push_back({2'b10, 32'h0000_0022});
        issue_cmd(5, 7, 2);
        wait_drain();

        // Reset after the HEADER of a len=4 packet aborts it
        exp_q.push_back({2'b01, 32'h3000_0004});
        issue_cmd(6, 0, 4);
        @(negedge clk);
        check("abort_header_valid", out_valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        data_q.delete();
        cnt_model = 16'd0;
        @(negedge clk);
        check("in_reset_out_valid", out_valid, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_in_ready", in_ready, 0);
`ifdef LISNOC_PACKETIZER_CNT_EN
        check("post_rst_pkt_count", pkt_count, 0);
`endif
        step();
        exp_q.push_back({2'b11, 32'h0800_0000});
        issue_cmd(1, 0, 0);
        wait_drain();
        @(negedge clk);
        check("post_rst_idle", out_valid, 0);
`ifdef LISNOC_PACKETIZER_CNT_EN
        check("one_pkt_count", pkt_count, 1);
`endif
        step();

        // Randomized packets, gaps and back-pressure
        or_mode  = 2;
        data_pct = 70;
        for (int p = 0; p < 60; p++) begin
            int l;
            l = $urandom_range(0, 9);
            if (l == 9) l = $urandom_range(9, 15);
            model_cmd($urandom_range(0, 31), $urandom_range(0, 7), l);
            repeat ($urandom_range(0, 2)) step();
        end
        wait_drain();
        or_mode = 0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
